alif_param_loader: RTL and testbench
====================================

# alif_param_loader

Serial configuration controller for the ALIF neuron datapath. It deserialises a framed parameter stream on `serial_data` while `load_mode` is high and holds it in a shadow bank. On a complete, valid frame it commits the shadow bank atomically to the active parameter bus that feeds the neuron core. It reports `params_ready`, `load_busy` and `frame_error` so the top level can gate neuron operation during reconfiguration.

## Interface
- `PARAM_COUNT`, 6: number of 8-bit parameters per frame.
- `DEFAULT_PARAMS`, 48'h40_03_08_02_05_7F: `param_bus` value after reset; byte 0 in the MSBs.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `enable` in 1: high = controller advances; low = FSM, counters and sampling frozen.
- `load_mode` in 1: high = configuration frame in progress.
- `serial_data` in 1: frame bit, MSB-first per byte, byte 0 first.
- `param_bus` out PARAM_COUNT*8: active parameters; byte i at bits [(PARAM_COUNT-i)*8-1 -: 8].
- `params_ready` out 1: a valid frame has been committed and no load is in progress.
- `load_busy` out 1: state is SHIFT or CHECK.
- `frame_error` out 1: the last frame was aborted or failed its checksum; sticky.

## Operation
- FSM states: IDLE, SHIFT, CHECK, WAIT_LOW. A cycle "counts" only when `enable`=1.
- IDLE:
  - `load_mode`=1 samples bit 0, clears `frame_error`, clears the bit and byte counters, then goes to SHIFT.
  - Otherwise stays in IDLE.
- SHIFT, `load_mode`=1:
  - Samples one bit per counted cycle into the 8-bit shifter.
  - On every 8th bit, the byte is written to `shadow[byte_idx]` and `byte_idx` increments.
  - After the last bit of the frame, goes to CHECK.
- SHIFT, `load_mode`=0 before the frame is complete: abort.
  - Sets `frame_error`=1, discards the shadow bank, goes to IDLE.
  - `param_bus` is unchanged; `params_ready` returns to its pre-load value.
- Frame length FRAME_BITS is PARAM_COUNT*8, plus 8 when the checksum is compiled in.
- CHECK (one counted cycle):
  - On pass: `param_bus` ← shadow and `params_ready`=1.
  - On fail: `frame_error`=1, no commit.
  - Always goes to WAIT_LOW. `load_mode` dropping during CHECK does not abort.
- WAIT_LOW: `serial_data` is ignored; extra bits are discarded. Goes to IDLE when `load_mode`=0.
- `params_ready`=0 while `load_busy`=1.
- `param_bus` never changes except by commit or reset.

## Timing
- Reset values: state IDLE, `param_bus`=DEFAULT_PARAMS, `params_ready`=0, `load_busy`=0, `frame_error`=0, shadow and counters 0.
- Bit i is sampled at counted edge i (i = 0..FRAME_BITS-1).
- Edge FRAME_BITS-1 enters CHECK. Commit or error is visible after edge FRAME_BITS, i.e. FRAME_BITS+1 counted edges after the first bit.
- `load_busy` rises after edge 0 and falls after edge FRAME_BITS.
- `enable`=0 inserts stall cycles: no bit is consumed and the abort check is suppressed.
- Abort is registered at the first counted edge in SHIFT with `load_mode`=0.
- `reset` mid-frame: immediate return to reset values; partial shadow data is lost.

## Configuration
- `ALIF_PARAM_CHECKSUM_EN` defined:
  - The frame carries a trailing checksum byte equal to the XOR of all parameter bytes.
  - CHECK passes only on a match; a mismatch sets `frame_error` and does not commit.
- Undefined: there is no checksum byte, FRAME_BITS = PARAM_COUNT*8, and CHECK always passes.

## Structure
- Package `alif_pkg` holds:
  - `PARAM_W`=8.
  - The FSM state enum.
  - Byte index constants: IDX_THRESH=0, IDX_LEAK=1, IDX_ADAPT_INC=2, IDX_ADAPT_DECAY=3, IDX_REFRAC=4, IDX_WEIGHT=5.
- Sub-module `alif_serial_shifter`: 8-bit MSB-first shifter with a 3-bit counter. It emits a one-cycle `byte_valid` pulse and the `byte_out` value, with `clear` and `enable` inputs.
- The FSM, byte counter, shadow bank, checksum accumulator and commit logic live in `alif_param_loader`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `param_bus`=48'h4003_0802_057F, `params_ready`=0, `load_busy`=0, `frame_error`=0 without waiting for a clock edge.
- Full frame, checksum off: stream 0x10,0x02,0x0C,0x01,0x07,0x33 (48 bits) → after edge 48, `param_bus`=48'h1002_0C01_0733, `params_ready`=1, `frame_error`=0.
- Abort: drop `load_mode` after 20 bits → `frame_error`=1, `param_bus` unchanged, `params_ready` equal to its pre-load value, state IDLE.
- Checksum on: parameter bytes 0x40,0x03,0x08,0x02,0x05,0x7F.
  - With checksum 0x33 → commit, `params_ready`=1.
  - With checksum 0x32 → `frame_error`=1, `param_bus` unchanged.
- Stall: hold `enable`=0 for 5 cycles after bit 17 → commit lands 5 cycles later with identical `param_bus`. Then hold `load_mode` high for 10 extra bits → they are ignored, and IDLE is entered after `load_mode` falls.
- Reset at bit 30 → reset values. A following full frame then loads correctly.

Source files
------------

// File: rtl/alif_pkg.sv
// Shared types and constants for the ALIF parameter loader.
// Optional checksum byte: define ALIF_PARAM_CHECKSUM_EN.
package alif_pkg;

  localparam int PARAM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_WAIT_LOW
  } state_t;

  localparam int IDX_THRESH      = 0;
  localparam int IDX_LEAK        = 1;
  localparam int IDX_ADAPT_INC   = 2;
  localparam int IDX_ADAPT_DECAY = 3;
  localparam int IDX_REFRAC      = 4;
  localparam int IDX_WEIGHT      = 5;

endpackage

// File: rtl/alif_serial_shifter.sv
// MSB-first 8-bit deserialiser with a 3-bit bit counter.
// byte_valid pulses on the sampling cycle that completes a byte.
import alif_pkg::*;

module alif_serial_shifter (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               serial_in,
  output logic               byte_valid,
  output logic [PARAM_W-1:0] byte_out,
  output logic               last_bit
);

  logic [PARAM_W-2:0] r_sr;
  logic [2:0]         r_cnt;
  logic [PARAM_W-2:0] w_sr;
  logic [2:0]         w_cnt;

  // clear acts before the shift so a new frame can sample its first bit
  assign w_sr       = clear ? '0 : r_sr;
  assign w_cnt      = clear ? '0 : r_cnt;
  assign byte_out   = {w_sr, serial_in};
  assign byte_valid = enable && (w_cnt == 3'd7);
  assign last_bit   = (r_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (enable) begin
      r_sr  <= byte_out[PARAM_W-2:0];
      r_cnt <= w_cnt + 3'd1;
    end else if (clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/alif_param_loader.sv
// Framed serial parameter loader with shadow bank and atomic commit.
// Optional trailing XOR checksum byte: define ALIF_PARAM_CHECKSUM_EN.
import alif_pkg::*;

module alif_param_loader #(
  parameter int PARAM_COUNT = 6,
  parameter logic [PARAM_COUNT*PARAM_W-1:0] DEFAULT_PARAMS =
    48'h40_03_08_02_05_7F
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           load_mode,
  input  logic                           serial_data,
  output logic [PARAM_COUNT*PARAM_W-1:0] param_bus,
  output logic                           params_ready,
  output logic                           load_busy,
  output logic                           frame_error
);

`ifdef ALIF_PARAM_CHECKSUM_EN
  localparam int NBYTES = PARAM_COUNT + 1;
`else
  localparam int NBYTES = PARAM_COUNT;
`endif
  localparam int IDXW = $clog2(NBYTES + 1);

  state_t r_state;
  state_t w_next;

  logic w_start;
  logic w_sample;
  logic w_clear;
  logic w_abort;
  logic w_check;
  logic w_check_ok;
  logic w_last;

  logic               w_byte_valid;
  logic [PARAM_W-1:0] w_byte;
  logic               w_bit7;

  logic [IDXW-1:0]    r_byte_idx;
  logic [PARAM_W-1:0] r_shadow [PARAM_COUNT];
  logic [PARAM_COUNT*PARAM_W-1:0] r_param_bus;
  logic               r_ready;
  logic               r_ferr;

  alif_serial_shifter u_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .enable    (w_sample),
    .serial_in (serial_data),
    .byte_valid(w_byte_valid),
    .byte_out  (w_byte),
    .last_bit  (w_bit7)
  );

  assign w_last = w_bit7 &&
    (r_byte_idx == IDXW'(NBYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_sample = 1'b0;
    w_clear  = 1'b0;
    w_abort  = 1'b0;
    w_check  = 1'b0;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: begin
          if (load_mode) begin
            w_start  = 1'b1;
            w_clear  = 1'b1;
            w_sample = 1'b1;
            w_next   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (load_mode) begin
            w_sample = 1'b1;
            if (w_last) w_next = ST_CHECK;
          end else begin
            w_abort = 1'b1;
            w_clear = 1'b1;
            w_next  = ST_IDLE;
          end
        end
        ST_CHECK: begin
          w_check = 1'b1;
          w_next  = ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!load_mode) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

`ifdef ALIF_PARAM_CHECKSUM_EN
  // running XOR over parameters and checksum: zero means match
  logic [PARAM_W-1:0] r_csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_csum <= '0;
    else if (w_start)      r_csum <= '0;
    else if (w_byte_valid) r_csum <= r_csum ^ w_byte;
  end

  assign w_check_ok = (r_csum == '0);
`else
  assign w_check_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_idx  <= '0;
      r_param_bus <= DEFAULT_PARAMS;
      r_ready     <= 1'b0;
      r_ferr      <= 1'b0;
      for (int i = 0; i < PARAM_COUNT; i++)
        r_shadow[i] <= '0;
    end else begin
      if (w_start) begin
        r_byte_idx <= '0;
        r_ferr     <= 1'b0;
      end
      if (w_byte_valid) begin
        if (r_byte_idx < IDXW'(PARAM_COUNT))
          r_shadow[r_byte_idx] <= w_byte;
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (w_abort) begin
        r_ferr     <= 1'b1;
        r_byte_idx <= '0;
        for (int i = 0; i < PARAM_COUNT; i++)
          r_shadow[i] <= '0;
      end
      if (w_check) begin
        if (w_check_ok) begin
          r_ready <= 1'b1;
          for (int i = 0; i < PARAM_COUNT; i++)
            r_param_bus[(PARAM_COUNT-i)*PARAM_W-1 -: PARAM_W]
              <= r_shadow[i];
        end else begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  assign load_busy    = (r_state == ST_SHIFT) ||
                        (r_state == ST_CHECK);
  assign params_ready = r_ready && !load_busy;
  assign frame_error  = r_ferr;
  assign param_bus    = r_param_bus;

endmodule

// File: tb/tb_alif_param_loader.sv
// Directed + random frame bench for alif_param_loader.
// Follows ALIF_PARAM_CHECKSUM_EN to size frames.
module tb_alif_param_loader;

  localparam int PC = 6;
  localparam int BW = PC * 8;
`ifdef ALIF_PARAM_CHECKSUM_EN
  localparam int FB = BW + 8;
  localparam bit CSUM = 1'b1;
`else
  localparam int FB = BW;
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [BW-1:0] DEF = 48'h40_03_08_02_05_7F;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load_mode;
  logic          serial_data;
  logic [BW-1:0] param_bus;
  logic          params_ready;
  logic          load_busy;
  logic          frame_error;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0] m_bus;
  logic          m_ready;
  logic          m_ferr;
  logic [BW-1:0] d;

  always #5 clk = ~clk;

  alif_param_loader dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load_mode   (load_mode),
    .serial_data (serial_data),
    .param_bus   (param_bus),
    .params_ready(params_ready),
    .load_busy   (load_busy),
    .frame_error (frame_error)
  );

  task automatic chk(input string tag,
                     input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy);
    chk({tag, "/bus"},   param_bus,          m_bus);
    chk({tag, "/ready"}, BW'(params_ready),  BW'(m_ready & ~busy));
    chk({tag, "/ferr"},  BW'(frame_error),   BW'(m_ferr));
    chk({tag, "/busy"},  BW'(load_busy),     BW'(busy));
  endtask

  // one clock: drive at a falling edge, return at the next one
  task automatic cyc(input logic en, input logic lm, input logic sd);
    enable      = en;
    load_mode   = lm;
    serial_data = sd;
    @(negedge clk);
  endtask

  function automatic logic [7:0] xsum(input logic [BW-1:0] v);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < PC; i++) x ^= v[i*8 +: 8];
    return x;
  endfunction

  task automatic run_frame(input string tag,
                           input logic [BW-1:0] data,
                           input logic [7:0] csum,
                           input int abort_at,
                           input int stall_at,
                           input int stall_len,
                           input int reset_at,
                           input int extra);
    logic b;
    logic ok;
    for (int i = 0; i < FB; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          cyc(1'b0, 1'b0, 1'($urandom));
          chk({tag, "/stall"}, BW'({load_busy, frame_error}),
              BW'(2'b10));
        end
      end
      if (i == abort_at) begin
        cyc(1'b1, 1'b0, 1'($urandom));
        m_ferr = 1'b1;
        chk_all({tag, "/abort"}, 1'b0);
        return;
      end
      if (i == reset_at) begin
        #2;
        load_mode = 1'b0;
        reset     = 1'b1;
        #1;
        m_bus   = DEF;
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        chk_all({tag, "/reset"}, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      b = (i < BW) ? data[BW-1-i] : csum[7-(i-BW)];
      cyc(1'b1, 1'b1, b);
      if (i == 0) begin
        m_ferr = 1'b0;
        chk_all({tag, "/start"}, 1'b1);
      end
    end
    chk_all({tag, "/check"}, 1'b1);
    cyc(1'b1, 1'b1, 1'($urandom));
    ok = !CSUM || (csum == xsum(data));
    if (ok) begin
      m_bus   = data;
      m_ready = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    chk_all({tag, "/commit"}, 1'b0);
    if (extra > 0) begin
      for (int e = 0; e < extra; e++) cyc(1'b1, 1'b1, 1'($urandom));
      chk_all({tag, "/extra"}, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk_all({tag, "/idle"}, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    load_mode   = 1'b0;
    serial_data = 1'b0;
    m_bus       = DEF;
    m_ready     = 1'b0;
    m_ferr      = 1'b0;
    #3;
    chk_all("por", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("idle0", 1'b0);

    d = 48'h1002_0C01_0733;
    run_frame("fixed", d, xsum(d), -1, -1, 0, -1, 0);

    for (int k = 0; k < 3; k++) begin
      d = BW'({$urandom, $urandom});
      run_frame("rand", d, xsum(d), -1, -1, 0, -1, 0);
    end

    d = BW'({$urandom, $urandom});
    run_frame("abort", d, xsum(d), 20, -1, 0, -1, 0);

    d = BW'({$urandom, $urandom});
    run_frame("stall", d, xsum(d), -1, 18, 5, -1, 10);

`ifdef ALIF_PARAM_CHECKSUM_EN
    run_frame("cs_ok", DEF, 8'h33, -1, -1, 0, -1, 0);
    d = BW'({$urandom, $urandom});
    run_frame("cs_rand", d, xsum(d), -1, -1, 0, -1, 0);
    run_frame("cs_bad", DEF, 8'h32, -1, -1, 0, -1, 0);
`endif

    d = BW'({$urandom, $urandom});
    run_frame("midrst", d, xsum(d), -1, -1, 0, 30, 0);

    d = BW'({$urandom, $urandom});
    run_frame("after_rst", d, xsum(d), -1, -1, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
